mem_responder: RTL and testbench

- Memory-side responder for the mini CPU's memory interface.
- Answers the control unit's Read/Write strobes using the MAR address and MDR write data.
- Holds a single-port word RAM and inserts programmable wait states.
- Returns read data toward the MDR plus a one-cycle Done pulse per completed access.
- Sits between the datapath's MAR/MDR registers and the memory array.

---
 rtl/cpu_mem_pkg.sv | 20 ++
 rtl/mem_array.sv | 23 ++
 rtl/mem_responder.sv | 124 ++++++++++++
 tb/tb_mem_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and default sizes for the mini-CPU memory responder.
package cpu_mem_pkg;

   localparam int unsigned DEF_ADDR_W      = 9;
   localparam int unsigned DEF_DATA_W      = 32;
   localparam int unsigned DEF_WAIT_STATES = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2,
      HOLD = 2'd3
   } state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with registered read data.
// The word width is chosen by the parent (one extra bit per word when MEM_PARITY_EN is defined).
module mem_array #(
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned WORD_W = 32
) (
   input  logic              Clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [0:(1 << ADDR_W)-1];

   always_ff @(posedge Clock) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: answers Read/Write strobes with programmable wait states and a Done pulse.
// Define MEM_PARITY_EN to store an even-parity bit per word and report mismatches on Parity_err.
module mem_responder
   import cpu_mem_pkg::*;
#(
   parameter int unsigned ADDR_W      = DEF_ADDR_W,
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned WAIT_STATES = DEF_WAIT_STATES
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Read,
   input  logic              Write,
   input  logic [ADDR_W-1:0] MAR_addr,
   input  logic [DATA_W-1:0] MDR_wdata,
   output logic [DATA_W-1:0] Mdata_in,
   output logic              Done,
   output logic              Busy,
   output logic              Req_err
`ifdef MEM_PARITY_EN
   ,
   output logic              Parity_err
`endif
);

`ifdef MEM_PARITY_EN
   localparam int unsigned WORD_W = DATA_W + 1;
`else
   localparam int unsigned WORD_W = DATA_W;
`endif
   localparam logic [3:0] WS = 4'(WAIT_STATES);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   op_t               op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              strobe, accept;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [WORD_W-1:0] ram_wdata, ram_rdata;

   assign strobe = Read | Write;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (strobe) begin
               accept  = 1'b1;
               cnt_d   = WS;
               state_d = (WS == 4'd0) ? ACK : WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = ACK;
            end
         end
         ACK:     state_d = HOLD;
         HOLD:    if (!strobe) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Present the live MAR address while idle so the RAM read is already valid
   // in ACK even with zero wait states.
   assign ram_addr = (state_q == IDLE) ? MAR_addr : addr_q;
   assign ram_we   = Reset && (state_q == ACK) && (op_q == OP_WR);
`ifdef MEM_PARITY_EN
   assign ram_wdata = {^wdata_q, wdata_q};
`else
   assign ram_wdata = wdata_q;
`endif

   mem_array #(
      .ADDR_W (ADDR_W),
      .WORD_W (WORD_W)
   ) u_array (
      .Clock (Clock),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         op_q       <= OP_RD;
         addr_q     <= '0;
         wdata_q    <= '0;
         Mdata_in   <= '0;
         Done       <= 1'b0;
         Busy       <= 1'b0;
         Req_err    <= 1'b0;
`ifdef MEM_PARITY_EN
         Parity_err <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         Busy    <= (state_d != IDLE);
         Done    <= (state_q == ACK);
         Req_err <= accept && Read && Write;
         if (accept) begin
            op_q    <= Write ? OP_WR : OP_RD;
            addr_q  <= MAR_addr;
            wdata_q <= MDR_wdata;
         end
         if (state_q == ACK && op_q == OP_RD) begin
            Mdata_in <= ram_rdata[DATA_W-1:0];
         end
`ifdef MEM_PARITY_EN
         Parity_err <= (state_q == ACK) && (op_q == OP_RD) && (^ram_rdata);
`endif
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT_STATES 1, 0, 15) share one stimulus stream
// and are checked every cycle against a transaction-level model.
module tb_mem_responder;

   logic              Clock = 1'b0;
   logic              Reset = 1'b0;
   logic              Read  = 1'b0;
   logic              Write = 1'b0;
   logic [8:0]        MAR   = '0;
   logic [31:0]       MDR   = '0;
   logic [2:0][31:0]  mdata;
   logic [2:0]        done, busy, rerr;
`ifdef MEM_PARITY_EN
   logic [2:0]        perr;
`endif

   always #5 Clock = ~Clock;

   mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(1)) u1 (
      .Clock(Clock), .Reset(Reset), .Read(Read), .Write(Write), .MAR_addr(MAR), .MDR_wdata(MDR),
      .Mdata_in(mdata[0]), .Done(done[0]), .Busy(busy[0]), .Req_err(rerr[0])
`ifdef MEM_PARITY_EN
      , .Parity_err(perr[0])
`endif
   );
   mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(0)) u0 (
      .Clock(Clock), .Reset(Reset), .Read(Read), .Write(Write), .MAR_addr(MAR), .MDR_wdata(MDR),
      .Mdata_in(mdata[1]), .Done(done[1]), .Busy(busy[1]), .Req_err(rerr[1])
`ifdef MEM_PARITY_EN
      , .Parity_err(perr[1])
`endif
   );
   mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(15)) u15 (
      .Clock(Clock), .Reset(Reset), .Read(Read), .Write(Write), .MAR_addr(MAR), .MDR_wdata(MDR),
      .Mdata_in(mdata[2]), .Done(done[2]), .Busy(busy[2]), .Req_err(rerr[2])
`ifdef MEM_PARITY_EN
      , .Parity_err(perr[2])
`endif
   );

   int          ws [3] = '{1, 0, 15};
   int          n_checks = 0;
   int          n_err = 0;
   int          cyc = 0;
   bit          model_ok = 1'b0;

   // Transaction-level model: one outstanding access per instance.
   logic [31:0] mmem [3][512];
   bit          mcor [3][512];
   bit          mbusy [3];
   bit          mwr [3];
   int          ma [3];
   logic [31:0] md [3];
   logic [31:0] mmd [3];
   int          done_at [3] = '{-1, -1, -1};
   int          rerr_at [3] = '{-1, -1, -1};
   int          perr_at [3] = '{-1, -1, -1};

   int          done_cnt [3] = '{0, 0, 0};
   int          rerr_cnt [3] = '{0, 0, 0};
   int          perr_cnt [3] = '{0, 0, 0};
   int          last_done [3] = '{0, 0, 0};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge Clock) begin
      cyc++;
      if (!Reset) model_ok = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (!Reset) begin
            mbusy[i]   = 1'b0;
            mmd[i]     = '0;
            done_at[i] = -1;
            rerr_at[i] = -1;
            perr_at[i] = -1;
         end else if (!mbusy[i]) begin
            if (Read || Write) begin
               mbusy[i]   = 1'b1;
               mwr[i]     = Write;
               ma[i]      = int'(MAR);
               md[i]      = MDR;
               done_at[i] = cyc + ws[i] + 1;
               if (Read && Write) rerr_at[i] = cyc;
            end
         end else if (cyc == done_at[i]) begin
            if (mwr[i]) begin
               mmem[i][ma[i]] = md[i];
               mcor[i][ma[i]] = 1'b0;
            end else begin
               mmd[i] = mmem[i][ma[i]];
               if (mcor[i][ma[i]]) perr_at[i] = cyc;
            end
         end else if (cyc > done_at[i] && !(Read || Write)) begin
            mbusy[i] = 1'b0;
         end
      end
   end

   always @(negedge Clock) begin
      if (model_ok) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("done[%0d]", i), 32'(done[i]), 32'(cyc == done_at[i]));
            chk($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(mbusy[i]));
            chk($sformatf("req_err[%0d]", i), 32'(rerr[i]), 32'(cyc == rerr_at[i]));
            chk($sformatf("mdata[%0d]", i), mdata[i], mmd[i]);
`ifdef MEM_PARITY_EN
            chk($sformatf("parity_err[%0d]", i), 32'(perr[i]), 32'(cyc == perr_at[i]));
            perr_cnt[i] += int'(perr[i]);
`endif
            if (done[i]) last_done[i] = cyc;
            done_cnt[i] += int'(done[i]);
            rerr_cnt[i] += int'(rerr[i]);
         end
      end
   end

   int acc_cyc;

   task automatic access(input bit rd, input bit wr, input int a, input logic [31:0] d, input int hold);
      int  base [3];
      int  k;
      bit  all_done;
      @(negedge Clock); #1;
      Read = rd; Write = wr; MAR = 9'(a); MDR = d;
      acc_cyc = cyc + 1;
      for (int i = 0; i < 3; i++) base[i] = done_cnt[i];
      k = 0;
      all_done = 1'b0;
      while ((k < hold || !all_done) && k < 60) begin
         @(negedge Clock); #1;
         k++;
         all_done = 1'b1;
         for (int i = 0; i < 3; i++) if (done_cnt[i] == base[i]) all_done = 1'b0;
      end
      chk("done_seen", 32'(all_done), 32'd1);
      chk("busy_while_held", 32'(busy), 32'h7);
      for (int i = 0; i < 3; i++) chk($sformatf("one_done[%0d]", i), done_cnt[i] - base[i], 1);
      Read = 1'b0; Write = 1'b0;
      k = 0;
      while (busy != 3'b000 && k < 10) begin
         @(negedge Clock); #1;
         k++;
      end
      chk("busy_released", 32'(busy), 32'h0);
   endtask

   initial begin
      int base [3];
      int rbase [3];
      logic [32:0] w;

      repeat (2) @(negedge Clock);
      #1;
      chk("reset_done", 32'(done), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_mdata0", mdata[0], 32'h0);
      Reset = 1'b1;

      // Basic write/read; latency literals for WAIT_STATES 1, 0, 15
      access(0, 1, 'h05, 32'hDEADBEEF, 3);
      chk("lat_ws1", last_done[0] - acc_cyc, 2);
      chk("lat_ws0", last_done[1] - acc_cyc, 1);
      chk("lat_ws15", last_done[2] - acc_cyc, 16);
      chk("write_keeps_mdata", mdata[0], 32'h0);
      access(1, 0, 'h05, 32'h0, 0);
      for (int i = 0; i < 3; i++) chk($sformatf("read05[%0d]", i), mdata[i], 32'hDEADBEEF);

      // Held read strobe: one Done only
      access(1, 0, 'h05, 32'h0, 20);

      // Simultaneous Read+Write: write wins, Req_err pulses once
      for (int i = 0; i < 3; i++) rbase[i] = rerr_cnt[i];
      access(1, 1, 'h10, 32'h12345678, 0);
      for (int i = 0; i < 3; i++) chk($sformatf("req_err_once[%0d]", i), rerr_cnt[i] - rbase[i], 1);
      chk("both_keeps_mdata", mdata[0], 32'hDEADBEEF);
      access(1, 0, 'h10, 32'h0, 0);
      for (int i = 0; i < 3; i++) chk($sformatf("read10[%0d]", i), mdata[i], 32'h12345678);

      // Top address does not alias onto 0x000
      access(0, 1, 'h000, 32'h0BADF00D, 0);
      access(0, 1, 'h1FF, 32'hFFFFFFFF, 0);
      access(1, 0, 'h000, 32'h0, 0);
      chk("read000", mdata[2], 32'h0BADF00D);
      access(1, 0, 'h1FF, 32'h0, 0);
      chk("read1ff", mdata[1], 32'hFFFFFFFF);

      // Reset during an in-flight write to 0x20 aborts it
      access(0, 1, 'h20, 32'hAAAA0000, 0);
      @(negedge Clock); #1;
      Write = 1'b1; MAR = 9'h20; MDR = 32'h55555555;
      for (int i = 0; i < 3; i++) base[i] = done_cnt[i];
      @(negedge Clock); #1;
      Reset = 1'b0; Write = 1'b0;
      @(negedge Clock); #1;
      Reset = 1'b1;
      repeat (20) @(negedge Clock);
      #1;
      for (int i = 0; i < 3; i++) chk($sformatf("no_done_abort[%0d]", i), done_cnt[i] - base[i], 0);
      chk("mdata_after_reset", mdata[0], 32'h0);
      access(1, 0, 'h20, 32'h0, 0);
      for (int i = 0; i < 3; i++) chk($sformatf("read20[%0d]", i), mdata[i], 32'hAAAA0000);

`ifdef MEM_PARITY_EN
      // Corrupt one stored data bit behind the responder's back
      access(0, 1, 'h30, 32'h00000001, 0);
      @(negedge Clock); #1;
      w = u1.u_array.mem[9'h30];  w[0] = ~w[0]; u1.u_array.mem[9'h30]  = w;
      w = u0.u_array.mem[9'h30];  w[0] = ~w[0]; u0.u_array.mem[9'h30]  = w;
      w = u15.u_array.mem[9'h30]; w[0] = ~w[0]; u15.u_array.mem[9'h30] = w;
      for (int i = 0; i < 3; i++) begin
         mmem[i][48] = mmem[i][48] ^ 32'h1;
         mcor[i][48] = 1'b1;
         base[i] = perr_cnt[i];
      end
      access(1, 0, 'h30, 32'h0, 0);
      for (int i = 0; i < 3; i++) chk($sformatf("parity_hit[%0d]", i), perr_cnt[i] - base[i], 1);
      chk("parity_data", mdata[0], 32'h0);
      for (int i = 0; i < 3; i++) base[i] = perr_cnt[i];
      access(1, 0, 'h05, 32'h0, 0);
      for (int i = 0; i < 3; i++) chk($sformatf("parity_clean[%0d]", i), perr_cnt[i] - base[i], 0);
`else
      w = '0;
`endif

      repeat (3) @(negedge Clock);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
